ipf_frame_sched: RTL and testbench
==================================

Name: ipf_frame_sched

Overview:
- Frame-level scheduler that feeds the IPF filter core one full image.
- Walks LCUs in raster order and prefetches per-LCU filter parameters from a parameter memory.
- Streams each LCU's pixels from the source image memory into the core as din/in_en, honouring core busy back-pressure.
- Counts core outputs and reports done/err when the core signals finish.

Parameters:
- IMG_W, 128, image width and height in pixels (square image).
- LCU_SIZE, 16, LCU edge in pixels; IMG_W/LCU_SIZE LCUs per row.
- LCU_SIZE_CODE, 2'd0, constant value driven on lcu_size.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
- ipf_busy  in  1  core back-pressure; no new pixel read issued while high.
- ipf_out_en  in  1  core output strobe.
- ipf_finish  in  1  core frame-complete flag.
- img_rdata  in  8  image memory read data, 1-cycle latency.
- prm_rdata  in  24  parameter word {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, 1-cycle latency.
- img_rd  out  1  image read strobe.
- img_addr  out  14  image address, (row<<7)|col.
- prm_rd  out  1  parameter read strobe.
- prm_addr  out  6  LCU index {ly[2:0], lx[2:0]}.
- in_en  out  1  pixel valid to core.
- din  out  8  pixel to core.
- ipf_type  out  2  current-LCU filter type.
- ipf_band_pos  out  5  current-LCU band position.
- ipf_wo_class  out  1  current-LCU WO class.
- ipf_offset  out  16  current-LCU offsets.
- lcu_x  out  3  current-LCU x index.
- lcu_y  out  3  current-LCU y index.
- lcu_size  out  2  constant LCU_SIZE_CODE.
- sched_busy  out  1  high from start until done.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky; set on output-count mismatch, cleared by start.
- out_cnt  out  15  number of ipf_out_en pulses this frame.

Behaviour:
- Reset values: all outputs 0, except lcu_size = LCU_SIZE_CODE. FSM returns to IDLE; counters and prefetch register cleared. Reset mid-frame abandons the frame immediately, with no done pulse.
- States: IDLE, PRM0, STREAM, DRAIN, DONE.
- IDLE: on start, go to PRM0 with prm_rd=1, prm_addr=0; clear out_cnt and err; raise sched_busy.
- PRM0: capture prm_rdata into the prefetch register, then go to STREAM.
- STREAM, pixel issue:
  - Each cycle with ipf_busy=0, issue img_rd for the next pixel: LCU k, row r, col c, with img_addr = ((k[5:3]*LCU_SIZE + r)<<7) | (k[2:0]*LCU_SIZE + c).
  - Order is c fastest, then r, then k.
  - With ipf_busy=1, no read is issued and the counters hold.
- STREAM, pixel delivery:
  - in_en and din equal the registered img_rd and img_rdata, so delivery is 1 cycle after issue.
  - A read already issued is always delivered, even if ipf_busy rose in between.
- Parameter presentation:
  - The ipf_* and lcu_x/lcu_y outputs load from the prefetch register in the same cycle the LCU's first pixel (r=0, c=0) is presented with in_en.
  - They hold until the next LCU's first pixel.
- Parameter prefetch: in the cycle the pixel read for (r=0, c=0) of LCU k issues, also issue prm_rd for LCU k+1 when k<63. prefetch captures the result on the next cycle.
- After the final pixel read (k=63, r=c=LCU_SIZE-1) issues, go to DRAIN. in_en for that pixel still appears the next cycle.
- DRAIN: wait for ipf_finish=1, then go to DONE.
- out_cnt increments on every ipf_out_en in any non-IDLE state and saturates at 2^15-1.
- DONE (1 cycle): pulse done and drop sched_busy.
  - err is set if out_cnt (including an ipf_out_en in the DONE cycle itself) differs from IMG_W*IMG_W = 16384.
  - Then go to IDLE.
- start while not IDLE is ignored.
- ipf_finish seen before DRAIN is ignored for FSM purposes; out_cnt still counts.
- Wrap-around: the k, r and c counters wrap to 0 only on a new start.

Test Plan:
- Reset mid-STREAM (reset high 2 cycles, then release) -> all outputs 0, FSM in IDLE; a later start produces a full, correct frame.
- Frame with ipf_busy=0 throughout, parameter words = LCU index -> in_en high for 16384 cycles, one per pixel.
  - First pixel img_addr 0; pixel 16 img_addr 128; LCU 1 first address 16; last address 16383.
  - ipf_offset shows 0..63 switching exactly at each LCU's first in_en.
- ipf_busy asserted for 5 cycles mid-LCU 3 -> exactly one in-flight pixel delivered after the rise; no addresses skipped or duplicated; resumes at the next address.
- Core model emitting 16384 ipf_out_en, then ipf_finish -> done pulses once, err=0, out_cnt=16384, sched_busy falls with done.
- Core model emitting 16383 outputs before ipf_finish -> done pulses, err=1; err stays 1 until the next start clears it.
- start pulsed during STREAM -> ignored; addresses and prm_addr sequence unchanged.

Source files
------------

// File: rtl/ipf_frame_sched_if.sv
// Bus bundle between the IPF frame scheduler and its environment
// (image/parameter memories, filter core, frame control).
interface ipf_frame_sched_if;
    logic        start;
    logic        ipf_busy;
    logic        ipf_out_en;
    logic        ipf_finish;
    logic [7:0]  img_rdata;
    logic [23:0] prm_rdata;
    logic        img_rd;
    logic [13:0] img_addr;
    logic        prm_rd;
    logic [5:0]  prm_addr;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        sched_busy;
    logic        done;
    logic        err;
    logic [14:0] out_cnt;

    modport master (
        input  start, ipf_busy, ipf_out_en, ipf_finish, img_rdata, prm_rdata,
        output img_rd, img_addr, prm_rd, prm_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, sched_busy, done, err, out_cnt
    );

    modport slave (
        output start, ipf_busy, ipf_out_en, ipf_finish, img_rdata, prm_rdata,
        input  img_rd, img_addr, prm_rd, prm_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size, sched_busy, done, err, out_cnt
    );
endinterface

// File: rtl/ipf_frame_sched.sv
// Frame scheduler for the IPF core: raster-walks LCUs, prefetches per-LCU
// parameters and streams pixels into the core under busy back-pressure.
module ipf_frame_sched #(
    parameter int         IMG_W         = 128,
    parameter int         LCU_SIZE      = 16,
    parameter logic [1:0] LCU_SIZE_CODE = 2'd0
) (
    input logic clk,
    input logic reset,
    ipf_frame_sched_if.master bus
);
    localparam int          LW        = $clog2(LCU_SIZE);
    localparam int          NW        = $clog2(IMG_W / LCU_SIZE);
    localparam logic [14:0] FRAME_PIX = 15'(IMG_W * IMG_W);

    typedef enum logic [2:0] {IDLE, PRM0, STREAM, DRAIN, DONE} state_t;

    state_t          state;
    logic [NW-1:0]   kx, ky;
    logic [LW-1:0]   r, c;
    logic            prm_rd_q;
    logic [5:0]      prm_addr_q;
    logic [23:0]     pf_data;
    logic [5:0]      pf_idx;
    logic            first_pix, last_pix;
    logic [14:0]     out_cnt_nxt;

    assign first_pix = (r == '0) && (c == '0);
    assign last_pix  = (&{ky, kx}) && (&r) && (&c);

    // Memories have one cycle of read latency: strobe/address are issued
    // combinationally in the issue cycle, data is valid the following cycle.
    assign bus.img_rd   = (state == STREAM) && !bus.ipf_busy;
    assign bus.img_addr = {ky, r, kx, c};
    assign bus.prm_rd   = ((state == IDLE) && bus.start) ||
                          (bus.img_rd && first_pix && !(&{ky, kx}));
    assign bus.prm_addr = (state == IDLE) ? 6'd0 : 6'({ky, kx} + 6'd1);
    assign bus.din      = bus.in_en ? bus.img_rdata : 8'd0;
    assign bus.lcu_size = LCU_SIZE_CODE;

    assign out_cnt_nxt = bus.out_cnt +
        15'((state != IDLE) && bus.ipf_out_en && !(&bus.out_cnt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            {kx, ky, r, c}   <= '0;
            prm_rd_q         <= 1'b0;
            prm_addr_q       <= '0;
            pf_data          <= '0;
            pf_idx           <= '0;
            bus.in_en        <= 1'b0;
            bus.ipf_type     <= '0;
            bus.ipf_band_pos <= '0;
            bus.ipf_wo_class <= 1'b0;
            bus.ipf_offset   <= '0;
            bus.lcu_x        <= '0;
            bus.lcu_y        <= '0;
            bus.sched_busy   <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.out_cnt      <= '0;
        end else begin
            bus.in_en  <= bus.img_rd;
            prm_rd_q   <= bus.prm_rd;
            prm_addr_q <= bus.prm_addr;
            bus.done   <= 1'b0;
            bus.out_cnt <= out_cnt_nxt;

            if (prm_rd_q) begin
                pf_data <= bus.prm_rdata;
                pf_idx  <= prm_addr_q;
            end

            // Registered here so the new parameters appear with the first in_en.
            if (bus.img_rd && first_pix) begin
                bus.ipf_type     <= pf_data[23:22];
                bus.ipf_band_pos <= pf_data[21:17];
                bus.ipf_wo_class <= pf_data[16];
                bus.ipf_offset   <= pf_data[15:0];
                bus.lcu_x        <= pf_idx[2:0];
                bus.lcu_y        <= pf_idx[5:3];
            end

            case (state)
                IDLE: if (bus.start) begin
                    state          <= PRM0;
                    bus.sched_busy <= 1'b1;
                    bus.out_cnt    <= '0;
                    bus.err        <= 1'b0;
                    {kx, ky, r, c} <= '0;
                end
                PRM0: state <= STREAM;
                STREAM: if (bus.img_rd) begin
                    if (last_pix) begin
                        state <= DRAIN;
                    end else begin
                        c <= c + 1'b1;
                        if (&c) begin
                            r <= r + 1'b1;
                            if (&r) {ky, kx} <= {ky, kx} + 1'b1;
                        end
                    end
                end
                DRAIN: if (bus.ipf_finish) begin
                    state          <= DONE;
                    bus.done       <= 1'b1;
                    bus.sched_busy <= 1'b0;
                end
                DONE: begin
                    if (out_cnt_nxt != FRAME_PIX) bus.err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipf_frame_sched.sv
// Scoreboard bench for ipf_frame_sched: expected issue addresses, parameter
// reads, delivered pixels and frame results are queued and checked by a monitor.
module tb_ipf_frame_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ipf_frame_sched_if bus();

    ipf_frame_sched dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int issued_cnt = 0;
    int core_cnt = 0;
    bit drop_first = 1'b0;

    logic [13:0] addr_q[$];
    logic [37:0] pix_q[$];
    logic [5:0]  prm_q[$];
    logic [15:0] done_q[$];

    function automatic logic [7:0] pix(input logic [13:0] a);
        return a[7:0] ^ {1'b0, a[13:7]};
    endfunction

    function automatic logic [23:0] prmw(input logic [5:0] a);
        return {a[1:0], a[4:0], a[5], 10'd0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual %0h required none", name, act);
    endtask

    // Memory and core models
    always @(posedge clk) begin
        if (bus.img_rd) bus.img_rdata <= pix(bus.img_addr);
        if (bus.prm_rd) bus.prm_rdata <= prmw(bus.prm_addr);
        if (bus.start) core_cnt <= 0;
        else if (bus.in_en) core_cnt <= core_cnt + 1;
        bus.ipf_out_en <= bus.in_en && !(drop_first && core_cnt == 0);
    end

    task automatic push_frame();
        for (int k = 0; k < 64; k++) begin
            logic [5:0] kb;
            kb = 6'(k);
            prm_q.push_back(kb);
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    logic [13:0] a;
                    a = 14'(((k / 8) * 16 + r) * 128 + (k % 8) * 16 + c);
                    addr_q.push_back(a);
                    pix_q.push_back({pix(a), kb[1:0], kb[4:0], kb[5], 16'(k),
                                     3'(k / 8), 3'(k % 8)});
                end
            end
        end
    endtask

    task automatic flush();
        addr_q.delete();
        pix_q.delete();
        prm_q.delete();
    endtask

    task automatic do_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic pulse_finish();
        @(posedge clk); #1 bus.ipf_finish = 1'b1;
        @(posedge clk); #1 bus.ipf_finish = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_outs_a"}, 64'({bus.img_rd, bus.img_addr, bus.prm_rd, bus.prm_addr,
                                   bus.in_en, bus.din, bus.sched_busy, bus.done,
                                   bus.err, bus.out_cnt}), 64'd0);
        chk({tag, "_outs_b"}, 64'({bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
                                   bus.ipf_offset, bus.lcu_x, bus.lcu_y}), 64'd0);
        chk({tag, "_lcu_size"}, 64'(bus.lcu_size), 64'd0);
    endtask

    task automatic wait_drain_and_done();
        int g;
        g = 0;
        while (pix_q.size() > 0 && g < 40000) begin @(posedge clk); g++; end
        if (pix_q.size() > 0) fail("drain_timeout", 64'(pix_q.size()));
        repeat (4) @(posedge clk);
        pulse_finish();
        g = 0;
        while (done_q.size() > 0 && g < 100) begin @(posedge clk); g++; end
        if (done_q.size() > 0) fail("done_timeout", 64'(done_q.size()));
        repeat (3) @(posedge clk);
    endtask

    // Monitor
    initial begin
        bit pend_err;
        bit exp_err;
        logic [15:0] d;
        pend_err = 1'b0;
        exp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.img_rd) begin
                    issued_cnt++;
                    if (addr_q.size() > 0) chk("img_addr", 64'(bus.img_addr), 64'(addr_q.pop_front()));
                    else fail("img_rd_unexpected", 64'(bus.img_addr));
                end
                if (bus.prm_rd) begin
                    if (prm_q.size() > 0) chk("prm_addr", 64'(bus.prm_addr), 64'(prm_q.pop_front()));
                    else fail("prm_rd_unexpected", 64'(bus.prm_addr));
                end
                if (bus.in_en) begin
                    if (pix_q.size() > 0)
                        chk("pixel", 64'({bus.din, bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
                                          bus.ipf_offset, bus.lcu_y, bus.lcu_x}),
                            64'(pix_q.pop_front()));
                    else fail("in_en_unexpected", 64'(bus.din));
                end
                if (pend_err) begin
                    chk("err_after_done", 64'(bus.err), 64'(exp_err));
                    pend_err = 1'b0;
                end
                if (bus.done) begin
                    if (done_q.size() > 0) begin
                        d = done_q.pop_front();
                        chk("out_cnt_at_done", 64'(bus.out_cnt), 64'(d[14:0]));
                        chk("busy_at_done", 64'(bus.sched_busy), 64'd0);
                        exp_err = d[15];
                        pend_err = 1'b1;
                    end else fail("done_unexpected", 64'(bus.out_cnt));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int base;
        int g;
        bus.start = 1'b0;
        bus.ipf_busy = 1'b0;
        bus.ipf_finish = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1 reset = 1'b0;

        // Aborted frame: reset held two cycles mid-STREAM
        push_frame();
        do_start();
        repeat (60) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_rst");
        @(posedge clk); #1 reset = 1'b0;
        flush();

        // Full frame: busy burst in LCU 3, stray start and finish, all outputs
        push_frame();
        done_q.push_back({1'b0, 15'd16384});
        base = issued_cnt;
        do_start();
        g = 0;
        while (issued_cnt - base < 3 * 256 + 100 && g < 40000) begin @(posedge clk); g++; end
        if (issued_cnt - base < 3 * 256 + 100) fail("issue_timeout", 64'(issued_cnt - base));
        #1 bus.ipf_busy = 1'b1;
        @(negedge clk);
        chk("busy_inflight", 64'(bus.in_en), 64'd1);
        chk("busy_no_issue", 64'(bus.img_rd), 64'd0);
        repeat (4) begin
            @(negedge clk);
            chk("busy_hold", 64'(bus.in_en), 64'd0);
        end
        @(posedge clk); #1 bus.ipf_busy = 1'b0;
        repeat (20) @(posedge clk);
        do_start();
        repeat (10) @(posedge clk);
        pulse_finish();
        @(negedge clk);
        chk("busy_mid_stream", 64'(bus.sched_busy), 64'd1);
        wait_drain_and_done();

        // Frame with one output missing: err must be raised and stay set
        drop_first = 1'b1;
        push_frame();
        done_q.push_back({1'b1, 15'd16383});
        do_start();
        wait_drain_and_done();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 64'(bus.err), 64'd1);
        drop_first = 1'b0;

        // Next start clears err and out_cnt; then abandon with reset
        push_frame();
        do_start();
        @(negedge clk);
        chk("err_cleared", 64'(bus.err), 64'd0);
        chk("out_cnt_cleared", 64'(bus.out_cnt), 64'd0);
        chk("busy_after_start", 64'(bus.sched_busy), 64'd1);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("end_rst");
        @(posedge clk); #1 reset = 1'b0;
        flush();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
